arb16_rr: RTL and testbench

- 16-requester round-robin arbiter for a single shared resource, e.g. a bus slot or register-port write path.
- Reduces the 16 request lines to an any-request flag and selects one winner with rotating priority.
- Holds the grant until the winner releases or a hold limit expires, then inserts a configurable dead gap before re-arbitrating.
- Sits between requesting units and the shared datapath; its grant drives the datapath select.

---
 rtl/arb16_rr.sv | 158 +++++++++++++++
 tb/tb_arb16_rr.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arb16_rr.sv
`default_nettype none
// ============================================================================
//  Module      : arb16_rr
//  Description : 16-requester round-robin arbiter for one shared resource.
//                The winner holds the grant until it releases or a hold limit
//                expires. A configurable dead gap follows before the next
//                arbitration.
//  Revision    : 1.0 - initial release
// ============================================================================
module arb16_rr #(
  parameter int unsigned MAXHOLD = 16,  // 1..255 cycles, 0 = unlimited
  parameter int unsigned GAP     = 1    // 0..15 dead cycles after a release
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        arb_en,
  input  logic [15:0] req,
  output logic        any_req,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_id,
  output logic        gnt_vld,
  output logic        timeout
);

  localparam logic [7:0] MAXHOLD_C = 8'(MAXHOLD);
  localparam logic [3:0] GAP_C     = 4'(GAP);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT   = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t      state, state_nx;
  logic [3:0]  ptr, ptr_nx;
  logic [7:0]  hold_cnt, hold_nx;
  logic [3:0]  gap_cnt, gap_nx;
  logic [15:0] gnt_nx;
  logic [3:0]  gnt_id_nx;
  logic        gnt_vld_nx;
  logic        timeout_nx;

  logic        found;
  logic [3:0]  winner;
  logic [3:0]  cand;
  logic        end_grant;

  // The request summary is purely combinational and ignores state and arb_en.
  assign any_req = |req;

  // Rotating-priority search: first set request starting at ptr, wrapping 15 -> 0.
  always_comb begin
    found  = 1'b0;
    winner = 4'd0;
    cand   = 4'd0;
    for (int i = 0; i < 16; i++) begin
      cand = ptr + 4'(i);
      if (!found && req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  // Next-state and registered-output computation for the arbitration FSM.
  always_comb begin
    state_nx   = state;
    ptr_nx     = ptr;
    hold_nx    = hold_cnt;
    gap_nx     = gap_cnt;
    gnt_nx     = gnt;
    gnt_id_nx  = gnt_id;
    gnt_vld_nx = gnt_vld;
    timeout_nx = 1'b0;
    end_grant  = 1'b0;

    case (state)
      IDLE: begin
        gnt_nx     = 16'd0;
        gnt_vld_nx = 1'b0;
        if (arb_en && found) begin
          gnt_nx     = 16'(1) << winner;
          gnt_id_nx  = winner;
          gnt_vld_nx = 1'b1;
          ptr_nx     = winner + 4'd1;
          hold_nx    = 8'd1;
          state_nx   = GRANT;
        end
      end

      GRANT: begin
        // Only the current winner's request line matters while granted.
        if (!req[gnt_id]) begin
          end_grant = 1'b1;
        end else if ((MAXHOLD_C != 8'd0) && (hold_cnt == MAXHOLD_C)) begin
          end_grant  = 1'b1;
          timeout_nx = 1'b1;
        end else if (hold_cnt != 8'hFF) begin
          // Saturate so an unlimited hold never wraps the counter.
          hold_nx = hold_cnt + 8'd1;
        end

        if (end_grant) begin
          gnt_nx     = 16'd0;
          gnt_vld_nx = 1'b0;
          if (GAP_C != 4'd0) begin
            gap_nx   = GAP_C;
            state_nx = HOLDOFF;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      HOLDOFF: begin
        gnt_nx     = 16'd0;
        gnt_vld_nx = 1'b0;
        if (gap_cnt <= 4'd1) begin
          gap_nx   = 4'd0;
          state_nx = IDLE;
        end else begin
          gap_nx = gap_cnt - 4'd1;
        end
      end

      default: begin
        gnt_nx     = 16'd0;
        gnt_vld_nx = 1'b0;
        state_nx   = IDLE;
      end
    endcase
  end

  // State and output registers; reset overrides any grant in progress.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state    <= IDLE;
      ptr      <= 4'd0;
      hold_cnt <= 8'd0;
      gap_cnt  <= 4'd0;
      gnt      <= 16'd0;
      gnt_id   <= 4'd0;
      gnt_vld  <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      hold_cnt <= hold_nx;
      gap_cnt  <= gap_nx;
      gnt      <= gnt_nx;
      gnt_id   <= gnt_id_nx;
      gnt_vld  <= gnt_vld_nx;
      timeout  <= timeout_nx;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_arb16_rr.sv
`default_nettype none
// ============================================================================
//  Module      : tb_arb16_rr
//  Description : Directed self-checking bench for arb16_rr. Three instances
//                cover unlimited hold, MAXHOLD=4 and a GAP=0 configuration.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_arb16_rr;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Instance A: MAXHOLD=0 (unlimited), GAP=1
  logic        rst_a, en_a, any_a, vld_a, to_a;
  logic [15:0] req_a, gnt_a;
  logic [3:0]  id_a;
  // Instance B: MAXHOLD=4, GAP=1
  logic        rst_b, en_b, any_b, vld_b, to_b;
  logic [15:0] req_b, gnt_b;
  logic [3:0]  id_b;
  // Instance C: MAXHOLD=2, GAP=0
  logic        rst_c, en_c, any_c, vld_c, to_c;
  logic [15:0] req_c, gnt_c;
  logic [3:0]  id_c;

  arb16_rr #(.MAXHOLD(0), .GAP(1)) u_a (
    .sys_clk(clk), .sys_rst(rst_a), .arb_en(en_a), .req(req_a),
    .any_req(any_a), .gnt(gnt_a), .gnt_id(id_a), .gnt_vld(vld_a), .timeout(to_a)
  );
  arb16_rr #(.MAXHOLD(4), .GAP(1)) u_b (
    .sys_clk(clk), .sys_rst(rst_b), .arb_en(en_b), .req(req_b),
    .any_req(any_b), .gnt(gnt_b), .gnt_id(id_b), .gnt_vld(vld_b), .timeout(to_b)
  );
  arb16_rr #(.MAXHOLD(2), .GAP(0)) u_c (
    .sys_clk(clk), .sys_rst(rst_c), .arb_en(en_c), .req(req_c),
    .any_req(any_c), .gnt(gnt_c), .gnt_id(id_c), .gnt_vld(vld_c), .timeout(to_c)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input string tag, input logic [15:0] g, input logic [3:0] id,
                          input logic v);
    check({tag, ".gnt"},     32'(gnt_a), 32'(g));
    check({tag, ".gnt_id"},  32'(id_a),  32'(id));
    check({tag, ".gnt_vld"}, 32'(vld_a), 32'(v));
    check({tag, ".timeout"}, 32'(to_a),  32'(0));
  endtask

  task automatic expect_b(input string tag, input logic [15:0] g, input logic [3:0] id,
                          input logic v, input logic t);
    check({tag, ".gnt"},     32'(gnt_b), 32'(g));
    check({tag, ".gnt_id"},  32'(id_b),  32'(id));
    check({tag, ".gnt_vld"}, 32'(vld_b), 32'(v));
    check({tag, ".timeout"}, 32'(to_b),  32'(t));
  endtask

  task automatic expect_c(input string tag, input logic [15:0] g, input logic [3:0] id,
                          input logic v, input logic t);
    check({tag, ".gnt"},     32'(gnt_c), 32'(g));
    check({tag, ".gnt_id"},  32'(id_c),  32'(id));
    check({tag, ".gnt_vld"}, 32'(vld_c), 32'(v));
    check({tag, ".timeout"}, 32'(to_c),  32'(t));
  endtask

  initial begin
    rst_a = 1'b1; en_a = 1'b1; req_a = 16'h0000;
    rst_b = 1'b1; en_b = 1'b1; req_b = 16'h0000;
    rst_c = 1'b1; en_c = 1'b1; req_c = 16'h0000;
    tick();
    tick();
    expect_a("reset", 16'h0000, 4'd0, 1'b0);
    expect_b("reset_b", 16'h0000, 4'd0, 1'b0, 1'b0);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick();

    // ---- Basic single grant and release ----
    check("any_req_idle", 32'(any_a), 32'(0));
    req_a = 16'h0001;
    #1;
    check("any_req_set", 32'(any_a), 32'(1));
    tick();
    expect_a("basic_grant", 16'h0001, 4'd0, 1'b1);
    req_a = 16'h0000;
    tick();
    expect_a("basic_release", 16'h0000, 4'd0, 1'b0);
    tick();
    tick();

    // ---- Rotation between requesters 0 and 15 ----
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    req_a = 16'h8001;
    tick();
    for (int k = 0; k < 4; k++) begin
      logic [3:0] w;
      w = (k % 2 == 1) ? 4'd15 : 4'd0;
      for (int c = 0; c < 3; c++) begin
        expect_a($sformatf("rot%0d_c%0d", k, c), 16'(1) << w, w, 1'b1);
        if (c < 2) tick();
      end
      req_a = 16'h8001 & ~(16'(1) << w);
      tick();
      expect_a($sformatf("rot%0d_rel", k), 16'h0000, w, 1'b0);
      req_a = 16'h8001;
      tick();
      expect_a($sformatf("rot%0d_gap", k), 16'h0000, w, 1'b0);
      tick();
    end
    expect_a("rot_fifth", 16'h0001, 4'd0, 1'b1);
    req_a = 16'h0000;
    tick();
    tick();
    tick();

    // ---- Wrap-around: ptr at 14 must pick 0 over 1 ----
    req_a = 16'h2000;
    tick();
    expect_a("wrap_g13", 16'h2000, 4'd13, 1'b1);
    req_a = 16'h0000;
    tick();
    expect_a("wrap_rel13", 16'h0000, 4'd13, 1'b0);
    tick();
    tick();
    req_a = 16'h0003;
    tick();
    expect_a("wrap_pick0", 16'h0001, 4'd0, 1'b1);
    req_a = 16'h0000;
    tick();
    tick();
    req_a = 16'h0003;
    tick();
    expect_a("wrap_ptr1", 16'h0002, 4'd1, 1'b1);
    req_a = 16'h0000;
    tick();
    tick();
    tick();

    // ---- arb_en gating ----
    en_a  = 1'b0;
    req_a = 16'hFFFF;
    #1;
    check("en_any_req", 32'(any_a), 32'(1));
    tick();
    tick();
    expect_a("en_low_nogrant", 16'h0000, 4'd1, 1'b0);
    en_a = 1'b1;
    tick();
    expect_a("en_grant2", 16'h0004, 4'd2, 1'b1);
    en_a = 1'b0;
    tick();
    expect_a("en_hold1", 16'h0004, 4'd2, 1'b1);
    tick();
    expect_a("en_hold2", 16'h0004, 4'd2, 1'b1);
    req_a = 16'hFFFB;
    tick();
    expect_a("en_rel", 16'h0000, 4'd2, 1'b0);
    tick();
    tick();
    tick();
    expect_a("en_low_after", 16'h0000, 4'd2, 1'b0);
    en_a = 1'b1;
    tick();
    expect_a("en_regrant3", 16'h0008, 4'd3, 1'b1);
    req_a = 16'h0000;
    tick();
    expect_a("en_rel3", 16'h0000, 4'd3, 1'b0);
    tick();
    tick();

    // ---- Reset in the middle of a grant ----
    req_a = 16'h0100;
    tick();
    expect_a("rst_g8", 16'h0100, 4'd8, 1'b1);
    req_a = 16'h0101;
    rst_a = 1'b1;
    tick();
    expect_a("rst_mid", 16'h0000, 4'd0, 1'b0);
    rst_a = 1'b0;
    tick();
    expect_a("rst_favour0", 16'h0001, 4'd0, 1'b1);
    req_a = 16'h0000;
    tick();
    tick();

    // ---- Timeout with MAXHOLD=4, GAP=1 ----
    req_b = 16'h0030;
    tick();
    for (int g = 0; g < 3; g++) begin
      logic [3:0] w;
      w = (g == 1) ? 4'd5 : 4'd4;
      for (int c = 0; c < 4; c++) begin
        expect_b($sformatf("to%0d_c%0d", g, c), 16'(1) << w, w, 1'b1, 1'b0);
        tick();
      end
      expect_b($sformatf("to%0d_pulse", g), 16'h0000, w, 1'b0, 1'b1);
      tick();
      expect_b($sformatf("to%0d_gap", g), 16'h0000, w, 1'b0, 1'b0);
      tick();
    end
    req_b = 16'h0000;

    // ---- MAXHOLD=2, GAP=0: re-grant right after timeout and release ----
    req_c = 16'h0001;
    tick();
    expect_c("g0_c0", 16'h0001, 4'd0, 1'b1, 1'b0);
    tick();
    expect_c("g0_c1", 16'h0001, 4'd0, 1'b1, 1'b0);
    tick();
    expect_c("g0_to", 16'h0000, 4'd0, 1'b0, 1'b1);
    tick();
    expect_c("g0_regrant", 16'h0001, 4'd0, 1'b1, 1'b0);
    req_c = 16'h0000;
    tick();
    expect_c("g0_rel", 16'h0000, 4'd0, 1'b0, 1'b0);
    req_c = 16'h0002;
    tick();
    expect_c("g0_next1", 16'h0002, 4'd1, 1'b1, 1'b0);
    req_c = 16'h0000;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
`default_nettype wire
